// File: rtl/lpif_ll_credit_fifo_tx.sv
// Downstream Logic Link TX stage: DEPTH-entry flit FIFO released one flit per
// cycle toward the PHY concat block, gated by link state and downstream credit.
module lpif_ll_credit_fifo_tx #(
   parameter int DATA_WIDTH   = 537,
   parameter int FIFO_DEPTH   = 16,
   parameter int CREDIT_WIDTH = 8
) (
   input  logic                    clk_wr,
   input  logic                    rst_wr,
   input  logic                    tx_online,
   input  logic [CREDIT_WIDTH-1:0] init_downstream_credit,
   input  logic [DATA_WIDTH-1:0]   user_data,
   input  logic                    user_valid,
   output logic                    user_ready,
   input  logic                    tx_downstream_pop_ovrd,
   input  logic                    rx_downstream_credit,
   output logic [DATA_WIDTH-1:0]   txfifo_downstream_data,
   output logic                    tx_downstream_valid,
   output logic [31:0]             tx_downstream_debug_status
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]           DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = '1;

   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic                    online_q, credit_ovf_q, credit_ovf_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    rise, fall, full, empty, push, pop, dec, inc;

   always_comb begin
      rise       = tx_online & ~online_q;
      fall       = ~tx_online & online_q;
      full       = (count_q == DEPTH_C);
      empty      = (count_q == '0);
      user_ready = tx_online & ~full;
      push       = user_valid & user_ready;
      // online_q in the pop term keeps the rise cycle from releasing a flit
      pop        = tx_online & online_q & ~empty &
                   ((credit_q != '0) | tx_downstream_pop_ovrd);
      dec        = pop & ~tx_downstream_pop_ovrd;
      inc        = rx_downstream_credit;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (fall) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push & ~pop)      count_d = count_q + CW'(1);
         else if (pop & ~push) count_d = count_q - CW'(1);
      end

      valid_d = pop;
      data_d  = pop ? mem_q[rd_ptr_q] : data_q;

      credit_d     = credit_q;
      credit_ovf_d = credit_ovf_q;
      if (rise) begin
         credit_d = init_downstream_credit;
      end else if (!tx_online) begin
         credit_d = '0;
      end else if (dec & ~inc) begin
         credit_d = credit_q - CREDIT_WIDTH'(1);
      end else if (inc & ~dec) begin
         if (credit_q == CRED_MAX) credit_ovf_d = 1'b1;
         else                      credit_d     = credit_q + CREDIT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         online_q     <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         credit_q     <= '0;
         credit_ovf_q <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
      end else begin
         online_q     <= tx_online;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         credit_q     <= credit_d;
         credit_ovf_q <= credit_ovf_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
      end
   end

   // storage carries no reset; only the output register does
   always_ff @(posedge clk_wr) begin
      if (push) mem_q[wr_ptr_q] <= user_data;
   end

   assign txfifo_downstream_data     = data_q;
   assign tx_downstream_valid        = valid_q;
   assign tx_downstream_debug_status = {8'(credit_q), 8'(count_q), tx_online,
                                        credit_ovf_q, full, empty, 12'h000};
endmodule

// File: tb/tb_lpif_ll_credit_fifo_tx.sv
// Bench for lpif_ll_credit_fifo_tx: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_lpif_ll_credit_fifo_tx;
   localparam int DW    = 537;
   localparam int DEPTH = 16;
   localparam int CRW   = 8;

   logic           clk = 1'b0;
   logic           rst, on, uv, ovrd, rc;
   logic [CRW-1:0] init;
   logic [DW-1:0]  ud;
   logic           ready, dvalid;
   logic [DW-1:0]  ddata;
   logic [31:0]    dbg;

   int n_vec = 0;
   int n_err = 0;

   lpif_ll_credit_fifo_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(CRW)) dut (
      .clk_wr(clk), .rst_wr(rst), .tx_online(on), .init_downstream_credit(init),
      .user_data(ud), .user_valid(uv), .user_ready(ready),
      .tx_downstream_pop_ovrd(ovrd), .rx_downstream_credit(rc),
      .txfifo_downstream_data(ddata), .tx_downstream_valid(dvalid),
      .tx_downstream_debug_status(dbg));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(1, 0));
      return r;
   endfunction

   // ---------------- reference model ----------------
   logic [DW-1:0] mq[$];
   logic [DW-1:0] obs[$];
   int            m_cred;
   bit            m_prev, m_ovf, m_valid;
   logic [DW-1:0] m_data;

   always @(posedge clk) begin
      bit            s_rst, s_on, s_uv, s_ovrd, s_rc, rdy, pop, dec;
      logic [7:0]    s_init;
      logic [DW-1:0] s_ud;
      logic [31:0]   exp_dbg;
      int            sz;
      s_rst = rst; s_on = on; s_uv = uv; s_ovrd = ovrd; s_rc = rc;
      s_init = init; s_ud = ud;
      if (s_rst) begin
         mq.delete(); m_cred = 0; m_prev = 0; m_ovf = 0; m_valid = 0; m_data = '0;
      end else begin
         rdy = s_on && (mq.size() != DEPTH);
         pop = s_on && m_prev && (mq.size() > 0) && (m_cred > 0 || s_ovrd);
         m_valid = pop;
         if (pop) m_data = mq.pop_front();
         if (s_uv && rdy) mq.push_back(s_ud);
         if (s_on && !m_prev) m_cred = s_init;
         else if (!s_on) begin
            m_cred = 0;
            if (m_prev) mq.delete();
         end else begin
            dec = pop && !s_ovrd;
            if (dec && !s_rc) m_cred--;
            else if (s_rc && !dec) begin
               if (m_cred == 255) m_ovf = 1;
               else m_cred++;
            end
         end
         m_prev = s_on;
      end
      #1;
      sz = mq.size();
      exp_dbg = {m_cred[7:0], sz[7:0], s_on, m_ovf, (sz == DEPTH), (sz == 0), 12'h000};
      chk("valid", dvalid, m_valid);
      chkd("data", ddata, m_data);
      chk("ready", ready, s_on && (sz != DEPTH));
      chk("status", dbg, exp_dbg);
      if (dvalid === 1'b1) obs.push_back(ddata);
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] d [8];

   task automatic do_reset();
      rst = 1; on = 0; uv = 0; ovrd = 0; rc = 0; init = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      obs.delete();
   endtask

   initial begin
      int acc;
      rst = 1; on = 0; uv = 0; ovrd = 0; rc = 0; init = '0; ud = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_status", dbg, 32'h0000_1000);
      chk("rst_ready", ready, 0);
      chk("rst_valid", dvalid, 0);

      // credit-limited release
      do_reset();
      on = 1; init = 8'd4;
      for (int k = 0; k < 6; k++) begin
         d[k] = rnd_data(); uv = 1; ud = d[k];
         @(negedge clk);
      end
      uv = 0;
      repeat (8) @(negedge clk);
      chk("cl_nout4", obs.size(), 4);
      for (int k = 0; k < 4; k++) if (k < obs.size()) chkd("cl_order", obs[k], d[k]);
      chk("cl_credit0", dbg[31:24], 0);
      chk("cl_count2", dbg[23:16], 2);
      rc = 1;
      repeat (2) @(negedge clk);
      rc = 0;
      repeat (6) @(negedge clk);
      chk("cl_nout6", obs.size(), 6);
      if (obs.size() == 6) begin
         chkd("cl_d4", obs[4], d[4]);
         chkd("cl_d5", obs[5], d[5]);
      end
      chk("cl_credit_end", dbg[31:24], 0);
      chk("cl_count_end", dbg[23:16], 0);

      // FIFO full with no credit
      do_reset();
      on = 1; init = 0;
      @(negedge clk);
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         uv = 1; ud = rnd_data();
         #1;
         if (ready) acc++;
         if (i == 16) chk("full_ready17", ready, 0);
         @(negedge clk);
      end
      uv = 0;
      @(negedge clk);
      chk("full_acc", acc, 16);
      chk("full_count", dbg[23:16], 16);
      chk("full_bit", dbg[13], 1);
      chk("full_noout", obs.size(), 0);

      // override release
      do_reset();
      on = 1; init = 0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         d[k] = rnd_data(); uv = 1; ud = d[k];
         @(negedge clk);
      end
      uv = 0;
      @(negedge clk);
      ovrd = 1;
      repeat (3) @(negedge clk);
      ovrd = 0;
      repeat (4) @(negedge clk);
      chk("ovrd_nout", obs.size(), 3);
      for (int k = 0; k < 3; k++) if (k < obs.size()) chkd("ovrd_order", obs[k], d[k]);
      chk("ovrd_credit", dbg[31:24], 0);

      // credit saturation
      do_reset();
      on = 1; init = 8'd255;
      repeat (2) @(negedge clk);
      rc = 1;
      @(negedge clk);
      rc = 0;
      @(negedge clk);
      chk("sat_credit", dbg[31:24], 255);
      chk("sat_ovf", dbg[14], 1);
      on = 0;
      repeat (2) @(negedge clk);
      chk("sat_ovf_offline", dbg[14], 1);
      chk("sat_credit_offline", dbg[31:24], 0);
      do_reset();
      chk("sat_ovf_cleared", dbg, 32'h0000_1000);

      // simultaneous pop and return
      do_reset();
      on = 1; init = 8'd3; uv = 1; ud = rnd_data();
      @(negedge clk);
      rc = 1;
      for (int i = 0; i < 8; i++) begin
         ud = rnd_data();
         @(negedge clk);
         chk("simul_credit3", dbg[31:24], 3);
      end
      uv = 0; rc = 0;
      repeat (4) @(negedge clk);

      // link drop mid-stream and re-rise
      do_reset();
      on = 1; init = 8'd7;
      for (int k = 0; k < 8; k++) begin
         uv = 1; ud = rnd_data();
         @(negedge clk);
      end
      uv = 0; on = 0;
      @(negedge clk);
      chk("drop_count", dbg[23:16], 0);
      chk("drop_credit", dbg[31:24], 0);
      chk("drop_valid", dvalid, 0);
      chk("drop_ready", ready, 0);
      on = 1; init = 8'd7; uv = 1; ud = rnd_data();
      @(negedge clk);
      uv = 0;
      chk("rerise_credit", dbg[31:24], 7);
      chk("rerise_novalid", dvalid, 0);
      repeat (4) @(negedge clk);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 59) == 0) on = ~on;
         init = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
         uv   = ($urandom_range(0, 2) != 0);
         ud   = rnd_data();
         ovrd = ($urandom_range(0, 19) == 0);
         rc   = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      rst = 0; uv = 0; rc = 0; ovrd = 0;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
